// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants: ALU opcode encodings and the state
//               encoding of the multi-cycle multiply sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // ALU opcodes understood by the shared EX-stage ALU
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_NOR = 6'b100111;
  localparam logic [5:0] ALU_SLL = 6'b000000;

  // Multiply sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] SHF  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Unsigned N x N shift-and-add multiplier (low N bits kept)
//               that borrows the shared EX-stage ALU for every add and
//               shift. Latency is fixed at 2N+1 cycles from the accepted
//               start to the done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer
  import cpu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         alu_own,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_op,
  input  logic [N-1:0] alu_out
);

  localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(N - 1);

  logic [1:0]       r_state;
  logic [N-1:0]     r_m;       // multiplicand, shifted left each iteration
  logic [N-1:0]     r_q;       // multiplier, shifted right each iteration
  logic [N-1:0]     r_p;       // partial-product accumulator
  logic [CNT_W-1:0] r_cnt;     // completed iterations
  logic [N-1:0]     r_result;  // last committed product

  // FSM and datapath registers; flush aborts from any busy state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_q      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_m     <= op_a;
            r_q     <= op_b;
            r_p     <= '0;
            r_cnt   <= '0;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            if (r_q[0]) begin
              r_p <= alu_out;
            end
            r_state <= SHF;
          end
        end
        SHF: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_m     <= alu_out;
            r_q     <= r_q >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= (r_cnt == c_LAST_ITER) ? DONE : ACC;
          end
        end
        DONE: begin
          // A flush in the done cycle discards the product entirely
          if (!flush) begin
            r_result <= r_p;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode; alu_op stays a legal opcode even when the ALU is not owned
  always_comb begin
    busy    = (r_state != IDLE);
    done    = 1'b0;
    result  = r_result;
    alu_own = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;
    case (r_state)
      ACC: begin
        alu_own = 1'b1;
        alu_a   = r_p;
        alu_b   = r_m;
      end
      SHF: begin
        alu_own = 1'b1;
        alu_op  = ALU_SLL;
        alu_a   = r_m;
        alu_b   = N'(1);
      end
      DONE: begin
        // Bypass so the product is visible in the same cycle as done
        if (!flush) begin
          done   = 1'b1;
          result = r_p;
        end
      end
      default: ;
    endcase
  end

endmodule : alu_mul_sequencer

`default_nettype wire
